// File: rtl/seg7_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scroll_ctrl: hex / scrolling-message content for the 8-digit    |
// | seven-segment driver.                               Revision: 1.0    |
// +----------------------------------------------------------------------+
module seg7_scroll_ctrl #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 24,
  parameter int LEN_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  input  logic             wr_last,
  input  logic             hex_valid,
  input  logic [31:0]      hex_data,
  input  logic             scroll_en,
  input  logic [DIV_W-1:0] scroll_period,
  output logic             o_disp_mode,
  output logic [63:0]      o_data,
  output logic [LEN_W-1:0] o_len
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] pos_q, pos_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [63:0]      data_q, data_d;
  logic             mode_q, mode_d;
  logic             ready_q;
  logic [7:0]       msg_q [DEPTH];
  logic [AW-1:0]    wr_addr;
  logic             accept;
  logic [63:0]      win;

  assign accept      = wr_valid & ready_q;
  assign wr_ready    = ready_q;
  assign o_data      = data_q;
  assign o_disp_mode = mode_q;
  assign o_len       = len_q;

  // Leftmost digit (7) shows msg[pos]; positions past the message are blank.
  always_comb begin
    win = '1;
    for (int j = 0; j < 8; j++) begin
      logic [LEN_W-1:0] idx;
      idx = pos_q + LEN_W'(j);
      if (idx < len_q) win[8*(7-j) +: 8] = msg_q[idx[AW-1:0]];
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    pos_d    = pos_q;
    tick_d   = tick_q;
    data_d   = data_q;
    mode_d   = mode_q;
    wr_addr  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_ptr_d = LEN_W'(1);
          if (wr_last) begin
            len_d   = LEN_W'(1);
            pos_d   = '0;
            tick_d  = '0;
            state_d = SCROLL;
          end else begin
            state_d = LOAD;
          end
        end else if (hex_valid) begin
          data_d = {32'h0, hex_data};
          mode_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_addr  = wr_ptr_q[AW-1:0];
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_last || (wr_ptr_q == LEN_W'(DEPTH - 1))) begin
            len_d   = wr_ptr_q + 1'b1;
            pos_d   = '0;
            tick_d  = '0;
            state_d = SCROLL;
          end
        end
      end
      SCROLL, HOLD: begin
        data_d = win;
        mode_d = 1'b1;
        if (scroll_en) begin
          state_d = SCROLL;
          if (tick_q == scroll_period) begin
            tick_d = '0;
            pos_d  = (pos_q == len_q + LEN_W'(7)) ? '0 : pos_q + 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
        // A new byte outranks a hex load; the old window stays up meanwhile.
        if (accept) begin
          wr_ptr_d = LEN_W'(1);
          pos_d    = '0;
          tick_d   = '0;
          if (wr_last) begin
            len_d   = LEN_W'(1);
            state_d = SCROLL;
          end else begin
            state_d = LOAD;
          end
        end else if (hex_valid) begin
          data_d  = {32'h0, hex_data};
          mode_d  = 1'b0;
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      pos_q    <= '0;
      tick_q   <= '0;
      data_q   <= '1;
      mode_q   <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      ready_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) msg_q[wr_addr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scroll_ctrl: scoreboard bench for seg7_scroll_ctrl.          |
// |                                                     Revision: 1.0    |
// +----------------------------------------------------------------------+
module tb_seg7_scroll_ctrl;

  localparam int DEPTH = 16;
  localparam int DIV_W = 24;
  localparam int LEN_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wr_valid, wr_ready, wr_last, hex_valid, scroll_en;
  logic [7:0]       wr_data;
  logic [31:0]      hex_data;
  logic [DIV_W-1:0] scroll_period;
  logic             o_disp_mode;
  logic [63:0]      o_data;
  logic [LEN_W-1:0] o_len;

  seg7_scroll_ctrl #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .hex_valid(hex_valid), .hex_data(hex_data),
    .scroll_en(scroll_en), .scroll_period(scroll_period),
    .o_disp_mode(o_disp_mode), .o_data(o_data), .o_len(o_len)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q [$];
  logic [7:0]  msg [DEPTH];
  int          mlen, mpos, mtick, period;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] window(input int p);
    logic [63:0] w;
    w = '1;
    for (int j = 0; j < 8; j++)
      if (p + j < mlen) w[8*(7-j) +: 8] = msg[p+j];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    wr_valid = 1'b1;
    wr_data  = b;
    wr_last  = last;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic model_start(input int len, input int per);
    mlen  = len;
    mpos  = 0;
    mtick = 0;
    period = per;
  endtask

  // Predict the window one edge ahead, then compare once the DUT has registered it.
  task automatic scroll_run(input int ncyc, input int hold_at, input int hold_len);
    for (int c = 0; c < ncyc; c++) begin
      logic se;
      se = !(c >= hold_at && c < hold_at + hold_len);
      scroll_en = se;
      exp_q.push_back(window(mpos));
      if (se) begin
        if (mtick == period) begin
          mtick = 0;
          mpos  = (mpos == mlen + 7) ? 0 : mpos + 1;
        end else begin
          mtick++;
        end
      end
      step();
      check("scroll_win", o_data, exp_q.pop_front());
      check("scroll_mode", 64'(o_disp_mode), 64'd1);
    end
    scroll_en = 1'b1;
  endtask

  initial begin
    wr_valid = 0; wr_data = 0; wr_last = 0; hex_valid = 0; hex_data = 0;
    scroll_en = 1; scroll_period = 0; rstn = 1;
    #1 rstn = 0;
    step(); step();
    check("rst_data",  o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_mode",  64'(o_disp_mode), 64'd1);
    check("rst_len",   64'(o_len), 64'd0);
    check("rst_ready", 64'(wr_ready), 64'd0);
    rstn = 1;
    step();
    check("ready_after_rst", 64'(wr_ready), 64'd1);

    hex_valid = 1; hex_data = 32'h1234_ABCD;
    step();
    hex_valid = 0;
    check("hex_data", o_data, 64'h0000_0000_1234_ABCD);
    check("hex_mode", 64'(o_disp_mode), 64'd0);

    // Short message with a hex strobe during LOAD that must be ignored.
    scroll_period = 2; scroll_en = 1;
    send_byte(8'hC0, 1'b0);
    hex_valid = 1; hex_data = 32'h5555_5555;
    step();
    hex_valid = 0;
    check("load_hex_ignored", o_data, 64'h0000_0000_1234_ABCD);
    send_byte(8'hF9, 1'b0);
    send_byte(8'hA4, 1'b1);
    check("short_len", 64'(o_len), 64'd3);
    check("short_mode_pre", 64'(o_disp_mode), 64'd0);
    msg[0] = 8'hC0; msg[1] = 8'hF9; msg[2] = 8'hA4;
    model_start(3, 2);
    check("short_first_win", window(0), 64'hC0F9A4FF_FFFFFFFF);
    scroll_run(36, 0, 0);
    scroll_run(40, 5, 20);

    hex_valid = 1; hex_data = 32'hFEDC_BA98;
    step();
    hex_valid = 0;
    check("hex_abort_data", o_data, 64'h0000_0000_FEDC_BA98);
    check("hex_abort_mode", 64'(o_disp_mode), 64'd0);

    // Overflow: 16 bytes fill the buffer, the 17th starts a new message.
    scroll_period = 5;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h10 + i), 1'b0);
      msg[i] = 8'(8'h10 + i);
    end
    check("ovf_len", 64'(o_len), 64'd16);
    check("ovf_hold_hex", o_data, 64'h0000_0000_FEDC_BA98);
    mlen = 16;
    send_byte(8'h20, 1'b0);
    check("ovf_first_win", o_data, window(0));
    check("ovf_mode", 64'(o_disp_mode), 64'd1);
    hex_valid = 1; hex_data = 32'hAAAA_AAAA;
    for (int i = 0; i < 5; i++) begin
      step();
      hex_valid = 0;
      check("ovf_load_hold", o_data, window(0));
    end
    send_byte(8'h55, 1'b1);
    check("ovf_new_len", 64'(o_len), 64'd2);
    msg[0] = 8'h20; msg[1] = 8'h55;
    model_start(2, 5);
    scroll_run(30, 0, 0);

    // Byte and hex strobe on the same edge: the byte wins.
    scroll_period = 0;
    wr_valid = 1; wr_data = 8'h92; wr_last = 1;
    hex_valid = 1; hex_data = 32'hDEAD_BEEF;
    step();
    wr_valid = 0; wr_last = 0; hex_valid = 0;
    check("coll_mode", 64'(o_disp_mode), 64'd1);
    check("coll_len", 64'(o_len), 64'd1);
    check("coll_nohex", 64'(o_data == 64'h0000_0000_DEAD_BEEF), 64'd0);
    msg[0] = 8'h92;
    model_start(1, 0);
    scroll_run(20, 0, 0);

    // Asynchronous reset mid-scroll.
    rstn = 0;
    #1;
    check("rst2_data",  o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst2_mode",  64'(o_disp_mode), 64'd1);
    check("rst2_len",   64'(o_len), 64'd0);
    check("rst2_ready", 64'(wr_ready), 64'd0);
    step(); step();
    rstn = 1;
    step();
    check("rst2_ready_after", 64'(wr_ready), 64'd1);
    check("rst2_blank_after", o_data, 64'hFFFF_FFFF_FFFF_FFFF);
    hex_valid = 1; hex_data = 32'hCAFE_F00D;
    step();
    hex_valid = 0;
    check("rst2_idle_hex", o_data, 64'h0000_0000_CAFE_F00D);
    check("rst2_idle_mode", 64'(o_disp_mode), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
